ctrl_pipe_chain: RTL
====================

Name: ctrl_pipe_chain

Overview:
- Parametrised chain of pipeline registers that carries decoded control bundles from decode through STAGES downstream stages (E/M/W by default).
- Adds behaviour the hand-built per-stage control flops lack: a valid bit per stage, and automatic upstream stall propagation.
- Also adds automatic bubble insertion behind a held stage, per-stage field masking that drops signals after their last consumer stage, and a saturating stall-cycle counter.
- Sits between the main/ALU decoders and the datapath; one instance replaces all control pipeline flops.

Parameters:
- STAGES, 3, number of register stages (stage 0 = E, 1 = M, 2 = W).
- WIDTH, 24, control bundle width in bits.
- KEEP_MASK, all ones (STAGES*WIDTH bits), per-stage keep mask; stage k mask = bits [k*WIDTH +: WIDTH]; cleared bits are forced to 0 in that stage.
- AUTO_STALL, 1, 1 = a hold in stage k+1 forces a hold in stage k; 0 = stall_i is used verbatim.
- CNT_W, 16, stall counter width.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- in_ctrl, in, WIDTH, control bundle from decode.
- in_valid, in, 1, in_ctrl carries a real instruction.
- stall_i, in, STAGES, external stall request per stage (bit k = stage k).
- flush_i, in, STAGES, external flush per stage.
- clr_cnt, in, 1, synchronous clear of stall_cnt.
- ctrl_o, out, STAGES*WIDTH, stage k bundle at [k*WIDTH +: WIDTH].
- valid_o, out, STAGES, stage k valid.
- hold_o, out, STAGES, effective hold per stage (combinational); decode must hold its own register when hold_o[0]=1.
- stall_cnt, out, CNT_W, cycles with hold_o[0]=1, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all valid_o=0, ctrl_o=0, stall_cnt=0. On deassertion, the first update is at the next rising edge.
- Effective hold:
  - AUTO_STALL=1: hold[STAGES-1]=stall_i[STAGES-1]; hold[k]=stall_i[k] | hold[k+1].
  - AUTO_STALL=0: hold[k]=stall_i[k].
  - hold_o=hold; it is purely combinational from stall_i.
- Per-stage update each edge, highest priority first:
  1. flush_i[k]: valid=0, ctrl=0.
  2. hold[k]: retain valid and ctrl.
  3. k=0: valid=in_valid; ctrl=in_valid ? (in_ctrl & mask0) : 0.
  4. k>0 and hold[k-1]=1: auto bubble, valid=0, ctrl=0. The upstream content is not advancing, so it must not be duplicated.
  5. k>0 otherwise: valid=valid[k-1]; ctrl=ctrl[k-1] & mask_k.
- Invariant: valid_o[k]=0 implies ctrl_o[k]=0 at all times. Zero control means no register, HI/LO or memory writes.
- Latency: an in_ctrl accepted at edge n appears at stage k after edge n+k, absent holds.
- Masking is applied on entry to each stage. A bit cleared at stage k stays 0 downstream even if mask_k+1 has it set.
- Flush and hold on the same stage in the same cycle: flush wins. With AUTO_STALL=1, a flushed stage still reports hold, so upstream stages stay held that cycle.
- AUTO_STALL=0 with stall only downstream: the upstream stage advances and overwrites. Integrators accept this as legacy behaviour.
- stall_cnt:
  - Each edge: clr_cnt=1 sets it to 0 (this has priority).
  - Otherwise, if hold[0]=1 and stall_cnt < 2^CNT_W-1, it increments by 1.
  - At the maximum value it holds.
- An asynchronous reset asserted mid-stall or mid-flush clears everything immediately, regardless of clk.

Test Plan (STAGES=3, WIDTH=8, KEEP_MASK stage0=FF, stage1=FF, stage2=0F, AUTO_STALL=1, CNT_W=4 unless stated):
- Flow: in_valid=1 with in_ctrl A5, 3C, 77 on consecutive edges.
  - After the 1st edge: stage0=A5.
  - After the 3rd edge: stage2=05 and valid_o=111; stage1=3C, stage0=77.
- Auto stall and bubble: pipeline full (00/A5/3C/77 flow), then stall_i=010 for one cycle.
  - hold_o=011.
  - Stages 0 and 1 keep their values; stage2 gets a bubble (valid_o[2]=0, ctrl=00).
  - stall_cnt=1.
  - The next cycle resumes with no duplicate.
- Flush versus hold: stall_i=001 and flush_i=001 in the same cycle.
  - Stage0 becomes valid=0, ctrl=00.
  - hold_o[0]=1, stage1 gets a bubble, stall_cnt increments.
- Legacy mode (AUTO_STALL=0): stall_i=100 with stages holding 11/22/33.
  - hold_o=100.
  - Stage2 keeps 03 (33&0F); stage1 becomes 11; stage1's old 22 is lost.
- Counter: hold stall_i[0]=1 for 20 cycles.
  - stall_cnt saturates at 15.
  - clr_cnt=1 together with stall gives 0.
  - The next held cycle gives 1.
- Reset mid-operation: rst=0 asserted between edges while the pipeline is full and stalled.
  - valid_o=000, ctrl_o=0, stall_cnt=0 immediately, before any edge.
  - After release, the first accepted in_ctrl reaches stage0 on the next edge.

Source files
------------

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline chain: per-stage valid, hold propagation, bubble
// insertion, per-stage field masking and a saturating stall-cycle counter.
module ctrl_pipe_chain #(
    parameter int                      STAGES     = 3,
    parameter int                      WIDTH      = 24,
    parameter logic [STAGES*WIDTH-1:0] KEEP_MASK  = '1,
    parameter bit                      AUTO_STALL = 1'b1,
    parameter int                      CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic                      in_valid,
    input  logic [STAGES-1:0]         stall_i,
    input  logic [STAGES-1:0]         flush_i,
    input  logic                      clr_cnt,
    output logic [STAGES*WIDTH-1:0]   ctrl_o,
    output logic [STAGES-1:0]         valid_o,
    output logic [STAGES-1:0]         hold_o,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic [STAGES-1:0] hold;

    // A held stage holds everything upstream of it when AUTO_STALL is set.
    always_comb begin
        logic chain;
        // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
        hold  = '0;
        chain = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain   = stall_i[k] | (AUTO_STALL & chain);
            hold[k] = chain;
        end
    end

    assign hold_o = hold;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = KEEP_MASK[k*WIDTH +: WIDTH];

        logic             validR;
        logic [WIDTH-1:0] ctrlR;

        if (k == 0) begin : g_head
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    validR <= 1'b0;
                    ctrlR  <= '0;
                end else if (flush_i[k]) begin
                    validR <= 1'b0;
                    ctrlR  <= '0;
                end else if (!hold[k]) begin
                    validR <= in_valid;
                    ctrlR  <= in_valid ? (in_ctrl & MASK) : '0;
                end
            end
        end else begin : g_tail
            // Upstream held: its content is not advancing, so insert a bubble instead of a copy.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    validR <= 1'b0;
                    ctrlR  <= '0;
                end else if (flush_i[k]) begin
                    validR <= 1'b0;
                    ctrlR  <= '0;
                end else if (!hold[k]) begin
                    if (hold[k-1]) begin
                        validR <= 1'b0;
                        ctrlR  <= '0;
                    end else begin
                        validR <= valid_o[k-1];
                        ctrlR  <= ctrl_o[(k-1)*WIDTH +: WIDTH] & MASK;
                    end
                end
            end
        end

        assign valid_o[k]                 = validR;
        assign ctrl_o[k*WIDTH +: WIDTH]   = ctrlR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (hold[0] && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
